// File: rtl/fetch_npc_unit.sv
// F-stage PC register, next-PC selection and F/D pipeline register.
// Control flow resolves in D with one delay slot; a not-taken branch-likely squashes its slot.
module fetch_npc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [31:0] F_Instr,
  input  logic [2:0]  D_BrType,
  input  logic        D_Zero,
  input  logic [15:0] D_Imm16,
  input  logic [25:0] D_Imm26,
  input  logic [31:0] D_RsData,
  output logic [31:0] F_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        D_Nullified
);

  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_BR   = 3'd1,
    BT_BRL  = 3'd2,
    BT_J    = 3'd3,
    BT_JR   = 3'd4
  } br_type_e;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_null_q, d_null_d;

  logic [31:0] br_target, j_target, seq_pc;

  assign seq_pc    = f_pc_q + 32'd4;
  assign br_target = d_pc_q + 32'd4 + {{14{D_Imm16[15]}}, D_Imm16, 2'b00};
  // Region bits come from the jump itself, not from its delay slot.
  assign j_target  = {d_pc_q[31:28], D_Imm26, 2'b00};

  always_comb begin
    f_pc_d    = f_pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_null_d  = d_null_q;
    if (!Stall) begin
      f_pc_d    = seq_pc;
      d_instr_d = F_Instr;
      d_pc_d    = f_pc_q;
      d_null_d  = 1'b0;
      case (D_BrType)
        BT_BR:  if (D_Zero) f_pc_d = br_target;
        BT_BRL: begin
          if (D_Zero) begin
            f_pc_d = br_target;
          end else begin
            d_instr_d = NOP_INSTR;
            d_null_d  = 1'b1;
          end
        end
        BT_J:    f_pc_d = j_target;
        BT_JR:   f_pc_d = D_RsData;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= RESET_PC;
      d_instr_q <= NOP_INSTR;
      d_pc_q    <= 32'd0;
      d_null_q  <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_null_q  <= d_null_d;
    end
  end

  assign F_PC        = f_pc_q;
  assign D_Instr     = d_instr_q;
  assign D_PC        = d_pc_q;
  assign D_PC8       = d_pc_q + 32'd8;
  assign D_Nullified = d_null_q;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed test-plan scenarios followed by random traffic, all scored against a reference model.
module tb_fetch_npc_unit;
  logic        clk = 1'b0;
  logic        reset, Stall, D_Zero;
  logic [31:0] F_Instr, D_RsData;
  logic [2:0]  D_BrType;
  logic [15:0] D_Imm16;
  logic [25:0] D_Imm26;
  logic [31:0] F_PC, D_Instr, D_PC, D_PC8;
  logic        D_Nullified;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_fpc, m_dinstr, m_dpc;
  logic        m_null;

  fetch_npc_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .F_Instr(F_Instr),
    .D_BrType(D_BrType), .D_Zero(D_Zero), .D_Imm16(D_Imm16), .D_Imm26(D_Imm26),
    .D_RsData(D_RsData), .F_PC(F_PC), .D_Instr(D_Instr), .D_PC(D_PC),
    .D_PC8(D_PC8), .D_Nullified(D_Nullified)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: next state from the architectural rules, in plain arithmetic.
  task automatic model_step();
    logic [31:0] nf, ni, np;
    logic        nn;
    int          off;
    if (reset) begin
      nf = 32'h3000; ni = 32'h0; np = 32'h0; nn = 1'b0;
    end else if (Stall) begin
      nf = m_fpc; ni = m_dinstr; np = m_dpc; nn = m_null;
    end else begin
      nf = m_fpc + 4; ni = F_Instr; np = m_fpc; nn = 1'b0;
      off = int'($signed(D_Imm16)) * 4;
      if ((D_BrType == 3'd1 || D_BrType == 3'd2) && D_Zero)
        nf = m_dpc + 4 + 32'(off);
      else if (D_BrType == 3'd3)
        nf = (m_dpc & 32'hF000_0000) + 32'(D_Imm26) * 4;
      else if (D_BrType == 3'd4)
        nf = D_RsData;
      else if (D_BrType == 3'd2) begin
        ni = 32'h0; nn = 1'b1;
      end
    end
    m_fpc = nf; m_dinstr = ni; m_dpc = np; m_null = nn;
  endtask

  task automatic step(input logic rst, input logic stl, input logic [2:0] bt,
                      input logic z, input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] rs);
    reset = rst; Stall = stl; D_BrType = bt; D_Zero = z;
    D_Imm16 = i16; D_Imm26 = i26; D_RsData = rs; F_Instr = $urandom | 32'h1;
    @(posedge clk);
    model_step();
    #1;
    chk("f_pc", F_PC, m_fpc);
    chk("d_instr", D_Instr, m_dinstr);
    chk("d_pc", D_PC, m_dpc);
    chk("d_pc8", D_PC8, m_dpc + 8);
    chk("d_null", {31'd0, D_Nullified}, {31'd0, m_null});
  endtask

  initial begin
    m_fpc = 0; m_dinstr = 0; m_dpc = 0; m_null = 0;
    reset = 1; Stall = 0; D_BrType = 0; D_Zero = 0; D_Imm16 = 0; D_Imm26 = 0;
    D_RsData = 0; F_Instr = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_fpc", F_PC, 32'h3000);
    chk("rst_dpc8", D_PC8, 32'h8);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("seq_fpc", F_PC, 32'h300C);
    chk("seq_dpc", D_PC, 32'h3008);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    // BEQ at D_PC=3010, back by 4 words
    step(0, 0, 1, 1, 16'hFFFC, 0, 0);
    chk("beq_fpc", F_PC, 32'h3004);
    chk("beq_dpc", D_PC, 32'h3014);
    chk("beq_null", {31'd0, D_Nullified}, 32'd0);
    // place a BRL at D_PC=3020, not taken
    step(0, 0, 4, 0, 0, 0, 32'h3020);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 2, 0, 16'h0040, 0, 0);
    chk("brl_fpc", F_PC, 32'h3028);
    chk("brl_dpc", D_PC, 32'h3024);
    chk("brl_instr", D_Instr, 32'h0);
    chk("brl_null", {31'd0, D_Nullified}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("brl_resume", F_PC, 32'h302C);
    // J at D_PC=3040
    step(0, 0, 4, 0, 0, 0, 32'h3040);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 3, 0, 0, 26'h0000C10, 0);
    chk("j_fpc", F_PC, 32'h3040);
    // JR stalled for two cycles, then released
    step(0, 1, 4, 1, 0, 0, 32'h4000);
    step(0, 1, 4, 0, 0, 0, 32'h4000);
    chk("stall_fpc", F_PC, 32'h3040);
    step(0, 0, 4, 0, 0, 0, 32'h4000);
    chk("jr_fpc", F_PC, 32'h4000);
    // reset during stall with taken BR in D
    step(1, 1, 1, 1, 16'h0010, 0, 0);
    chk("rst_br_fpc", F_PC, 32'h3000);
    chk("rst_br_instr", D_Instr, 32'h0);
    // wrap-around and large negative offset
    step(0, 0, 4, 0, 0, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_fpc", F_PC, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_dpc", D_PC, 32'h0);
    step(0, 0, 1, 1, 16'h8000, 0, 0);
    chk("neg_off_fpc", F_PC, 32'hFFFE_0004);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 26'($urandom), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
